// File: rtl/coeff_token_pkg.sv
// coeff_token_pkg: shared types and constants for the CAVLC coeff_token encoder.
// Optional build macro used elsewhere: COEFF_TOKEN_CHECK_EN.
package coeff_token_pkg;

    localparam int MAX_LEN       = 16;
    localparam int LEN_W         = 5;
    localparam int NC_FLC_THRESH = 8;

    localparam logic [5:0] FLC_ZERO_CODE = 6'b000011;

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        SHIFT
    } state_t;

    typedef struct packed {
        logic [MAX_LEN-1:0] code;
        logic [LEN_W-1:0]   len;
    } code_t;

    // Build a left-aligned code entry from a right-aligned value and its length.
    function automatic code_t mk_code(input int l, input int v);
        code_t c;
        c.len  = LEN_W'(l);
        c.code = MAX_LEN'(v) << (MAX_LEN - l);
        return c;
    endfunction

endpackage

// File: rtl/coeff_token_if.sv
// coeff_token_if: token input and 1-bit serial output handshakes.
// Error is present only when COEFF_TOKEN_CHECK_EN is defined.
interface coeff_token_if;
    import coeff_token_pkg::*;

    logic             InValid;
    logic             InReady;
    logic [4:0]       TotalCoeff;
    logic [1:0]       TrailingOnes;
    logic [4:0]       nC;
    logic             OutValid;
    logic             OutReady;
    logic             OutBit;
    logic             OutLast;
    logic [LEN_W-1:0] CodeLen;

`ifdef COEFF_TOKEN_CHECK_EN
    logic             Error;

    modport master (
        output InValid, TotalCoeff, TrailingOnes, nC, OutReady,
        input  InReady, OutValid, OutBit, OutLast, CodeLen, Error
    );

    modport slave (
        input  InValid, TotalCoeff, TrailingOnes, nC, OutReady,
        output InReady, OutValid, OutBit, OutLast, CodeLen, Error
    );
`else
    modport master (
        output InValid, TotalCoeff, TrailingOnes, nC, OutReady,
        input  InReady, OutValid, OutBit, OutLast, CodeLen
    );

    modport slave (
        input  InValid, TotalCoeff, TrailingOnes, nC, OutReady,
        output InReady, OutValid, OutBit, OutLast, CodeLen
    );
`endif

endinterface

// File: rtl/coeff_token_enc_lut02.sv
// coeff_token_enc_lut02: coeff_token codes for the 0 <= nC < 2 context.
// Combinational; codes are left-aligned in a MAX_LEN field.
module coeff_token_enc_lut02
    import coeff_token_pkg::*;
(
    input  logic [4:0] tc,
    input  logic [1:0] t1,
    output code_t      ent
);

    // Map (TrailingOnes, TotalCoeff) to its variable-length codeword.
    always_comb begin
        ent = '0;
        case ({t1, tc})
            {2'd0, 5'd0}:  ent = mk_code(1,  'b1);
            {2'd0, 5'd1}:  ent = mk_code(6,  'b000101);
            {2'd1, 5'd1}:  ent = mk_code(2,  'b01);
            {2'd0, 5'd2}:  ent = mk_code(8,  'b00000111);
            {2'd1, 5'd2}:  ent = mk_code(6,  'b000100);
            {2'd2, 5'd2}:  ent = mk_code(3,  'b001);
            {2'd0, 5'd3}:  ent = mk_code(9,  'b000000111);
            {2'd1, 5'd3}:  ent = mk_code(8,  'b00000110);
            {2'd2, 5'd3}:  ent = mk_code(7,  'b0000101);
            {2'd3, 5'd3}:  ent = mk_code(5,  'b00011);
            {2'd0, 5'd4}:  ent = mk_code(10, 'b0000000111);
            {2'd1, 5'd4}:  ent = mk_code(9,  'b000000110);
            {2'd2, 5'd4}:  ent = mk_code(8,  'b00000101);
            {2'd3, 5'd4}:  ent = mk_code(6,  'b000011);
            {2'd0, 5'd5}:  ent = mk_code(11, 'b00000000111);
            {2'd1, 5'd5}:  ent = mk_code(10, 'b0000000110);
            {2'd2, 5'd5}:  ent = mk_code(9,  'b000000101);
            {2'd3, 5'd5}:  ent = mk_code(7,  'b0000100);
            {2'd0, 5'd6}:  ent = mk_code(13, 'b0000000001111);
            {2'd1, 5'd6}:  ent = mk_code(11, 'b00000000110);
            {2'd2, 5'd6}:  ent = mk_code(10, 'b0000000101);
            {2'd3, 5'd6}:  ent = mk_code(8,  'b00000100);
            {2'd0, 5'd7}:  ent = mk_code(13, 'b0000000001011);
            {2'd1, 5'd7}:  ent = mk_code(13, 'b0000000001110);
            {2'd2, 5'd7}:  ent = mk_code(11, 'b00000000101);
            {2'd3, 5'd7}:  ent = mk_code(9,  'b000000100);
            {2'd0, 5'd8}:  ent = mk_code(13, 'b0000000001000);
            {2'd1, 5'd8}:  ent = mk_code(13, 'b0000000001010);
            {2'd2, 5'd8}:  ent = mk_code(13, 'b0000000001101);
            {2'd3, 5'd8}:  ent = mk_code(10, 'b0000000100);
            {2'd0, 5'd9}:  ent = mk_code(14, 'b00000000001111);
            {2'd1, 5'd9}:  ent = mk_code(14, 'b00000000001110);
            {2'd2, 5'd9}:  ent = mk_code(13, 'b0000000001001);
            {2'd3, 5'd9}:  ent = mk_code(11, 'b00000000100);
            {2'd0, 5'd10}: ent = mk_code(14, 'b00000000001011);
            {2'd1, 5'd10}: ent = mk_code(14, 'b00000000001010);
            {2'd2, 5'd10}: ent = mk_code(14, 'b00000000001101);
            {2'd3, 5'd10}: ent = mk_code(13, 'b0000000001100);
            {2'd0, 5'd11}: ent = mk_code(15, 'b000000000001111);
            {2'd1, 5'd11}: ent = mk_code(15, 'b000000000001110);
            {2'd2, 5'd11}: ent = mk_code(14, 'b00000000001001);
            {2'd3, 5'd11}: ent = mk_code(14, 'b00000000001100);
            {2'd0, 5'd12}: ent = mk_code(15, 'b000000000001011);
            {2'd1, 5'd12}: ent = mk_code(15, 'b000000000001010);
            {2'd2, 5'd12}: ent = mk_code(15, 'b000000000001101);
            {2'd3, 5'd12}: ent = mk_code(14, 'b00000000001000);
            {2'd0, 5'd13}: ent = mk_code(16, 'b0000000000001111);
            {2'd1, 5'd13}: ent = mk_code(15, 'b000000000000001);
            {2'd2, 5'd13}: ent = mk_code(15, 'b000000000001001);
            {2'd3, 5'd13}: ent = mk_code(15, 'b000000000001100);
            {2'd0, 5'd14}: ent = mk_code(16, 'b0000000000001011);
            {2'd1, 5'd14}: ent = mk_code(16, 'b0000000000001110);
            {2'd2, 5'd14}: ent = mk_code(16, 'b0000000000001101);
            {2'd3, 5'd14}: ent = mk_code(15, 'b000000000001000);
            {2'd0, 5'd15}: ent = mk_code(16, 'b0000000000000111);
            {2'd1, 5'd15}: ent = mk_code(16, 'b0000000000001010);
            {2'd2, 5'd15}: ent = mk_code(16, 'b0000000000001001);
            {2'd3, 5'd15}: ent = mk_code(16, 'b0000000000001100);
            {2'd0, 5'd16}: ent = mk_code(16, 'b0000000000000100);
            {2'd1, 5'd16}: ent = mk_code(16, 'b0000000000000110);
            {2'd2, 5'd16}: ent = mk_code(16, 'b0000000000000101);
            {2'd3, 5'd16}: ent = mk_code(16, 'b0000000000001000);
            default:       ent = '0;
        endcase
    end

endmodule

// File: rtl/coeff_token_encoder.sv
// coeff_token_encoder: looks up a coeff_token codeword and shifts it out MSB first.
// COEFF_TOKEN_CHECK_EN adds an Error pulse and drops illegal tokens silently.
module coeff_token_encoder
    import coeff_token_pkg::*;
(
    input  logic          Clk,
    input  logic          nReset,
    coeff_token_if.slave  bus
);

    localparam logic [4:0] NC_LUT_MAX = 5'd1;
    localparam logic [4:0] NC_FLC     = 5'(NC_FLC_THRESH);
    localparam logic [4:0] TC_MAX     = 5'd16;

    state_t             state;
    logic [4:0]         tc_q;
    logic [4:0]         nc_q;
    logic [1:0]         t1_q;
    logic [MAX_LEN-1:0] code_q;
    logic [LEN_W-1:0]   cnt_q;
    logic [LEN_W-1:0]   len_q;
    logic               in_ready_q;
    logic               out_valid_q;

    code_t              lut;
    code_t              sel;
    logic [4:0]         tc_m1;
    logic [1:0]         t1_max;
    logic [5:0]         flc6;
    logic               illegal;

    coeff_token_enc_lut02 u_lut (
        .tc  (tc_q),
        .t1  (t1_q),
        .ent (lut)
    );

    // Classify the held token and choose the VLC table, the FLC code or the one-bit filler.
    always_comb begin
        tc_m1   = tc_q - 5'd1;
        t1_max  = (tc_q > 5'd3) ? 2'd3 : tc_q[1:0];
        illegal = (tc_q > TC_MAX) || (t1_q > t1_max) ||
                  ((nc_q > NC_LUT_MAX) && (nc_q < NC_FLC));
        flc6    = (tc_q == 5'd0) ? FLC_ZERO_CODE : {tc_m1[3:0], t1_q};
        sel     = lut;
        if (illegal) begin
            sel = mk_code(1, 0);
        end else if (nc_q >= NC_FLC) begin
            sel.code = {flc6, {(MAX_LEN-6){1'b0}}};
            sel.len  = LEN_W'(6);
        end
    end

    assign bus.InReady  = in_ready_q;
    assign bus.OutValid = out_valid_q;
    assign bus.OutBit   = code_q[MAX_LEN-1];
    assign bus.OutLast  = out_valid_q && (cnt_q == LEN_W'(1));
    assign bus.CodeLen  = len_q;

`ifdef COEFF_TOKEN_CHECK_EN
    logic err_q;
    assign bus.Error = err_q;
`endif

    // Token FSM: capture, look up, then shift one bit per output handshake.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state       <= IDLE;
            tc_q        <= '0;
            nc_q        <= '0;
            t1_q        <= '0;
            code_q      <= '0;
            cnt_q       <= '0;
            len_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef COEFF_TOKEN_CHECK_EN
            err_q       <= 1'b0;
`endif
        end else begin
`ifdef COEFF_TOKEN_CHECK_EN
            err_q <= 1'b0;
`endif
            unique case (state)
                IDLE: begin
                    if (bus.InValid) begin
                        tc_q       <= bus.TotalCoeff;
                        t1_q       <= bus.TrailingOnes;
                        nc_q       <= bus.nC;
                        in_ready_q <= 1'b0;
                        state      <= LOOKUP;
                    end
                end
                LOOKUP: begin
`ifdef COEFF_TOKEN_CHECK_EN
                    if (illegal) begin
                        err_q      <= 1'b1;
                        in_ready_q <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        code_q      <= sel.code;
                        cnt_q       <= sel.len;
                        len_q       <= sel.len;
                        out_valid_q <= 1'b1;
                        state       <= SHIFT;
                    end
`else
                    code_q      <= sel.code;
                    cnt_q       <= sel.len;
                    len_q       <= sel.len;
                    out_valid_q <= 1'b1;
                    state       <= SHIFT;
`endif
                end
                SHIFT: begin
                    if (bus.OutReady) begin
                        code_q <= code_q << 1;
                        cnt_q  <= cnt_q - LEN_W'(1);
                        if (cnt_q == LEN_W'(1)) begin
                            out_valid_q <= 1'b0;
                            in_ready_q  <= 1'b1;
                            state       <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_coeff_token_encoder.sv
// tb_coeff_token_encoder: directed vectors for the coeff_token encoder.
// Expected codewords are hand-derived from the nC<2 VLC table and the 6-bit FLC.
module tb_coeff_token_encoder;
    import coeff_token_pkg::*;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    coeff_token_if bus ();

    coeff_token_encoder dut (
        .Clk    (clk),
        .nReset (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  nc;
        logic [4:0]  tc;
        logic [1:0]  t1;
        int          len;
        logic [15:0] bits;
        string       nm;
    } vec_t;

    task automatic send(input logic [4:0] nc, input logic [4:0] tc, input logic [1:0] t1);
        bus.nC           = nc;
        bus.TotalCoeff   = tc;
        bus.TrailingOnes = t1;
        bus.InValid      = 1'b1;
        @(posedge clk);
        #1;
        bus.InValid      = 1'b0;
    endtask

    task automatic collect(input bit stall, output logic [15:0] bits, output int n,
                           output int lat, output int last_at, output int clen,
                           output bit held, output bit rdy_lo, output logic rdy_after);
        int k;
        logic pb;
        logic pl;
        logic [LEN_W-1:0] pc;
        bit prev_stall;
        bits = '0; n = 0; lat = 0; last_at = 0; clen = 0;
        held = 1'b1; rdy_lo = 1'b1; prev_stall = 1'b0;
        pb = 1'b0; pl = 1'b0; pc = '0;
        while (!bus.OutValid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        clen = int'(bus.CodeLen);
        k = 0;
        while (bus.OutValid && k < 60) begin
            if (prev_stall && (bus.OutBit !== pb || bus.OutLast !== pl || bus.CodeLen !== pc))
                held = 1'b0;
            if (int'(bus.CodeLen) != clen) held = 1'b0;
            if (bus.InReady !== 1'b0) rdy_lo = 1'b0;
            bus.OutReady = stall ? ((k % 4 == 0) || (k % 4 == 3)) : 1'b1;
            pb = bus.OutBit; pl = bus.OutLast; pc = bus.CodeLen;
            prev_stall = !bus.OutReady;
            if (bus.OutReady) begin
                bits = {bits[14:0], bus.OutBit};
                n++;
                if (bus.OutLast && last_at == 0) last_at = n;
            end
            @(posedge clk); #1; k++;
        end
        bus.OutReady = 1'b1;
        rdy_after = bus.InReady;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.InValid = 1'b0; bus.OutReady = 1'b1;
        bus.nC = '0; bus.TotalCoeff = '0; bus.TrailingOnes = '0;
        #7;
        vectors++;
        if (bus.InReady !== 1'b1 || bus.OutValid !== 1'b0 || bus.OutBit !== 1'b0 ||
            bus.OutLast !== 1'b0 || bus.CodeLen !== '0) begin
            miscompares++;
            $display("FAIL reset_values: got rdy=%b vld=%b bit=%b last=%b len=%0d want 1 0 0 0 0",
                     bus.InReady, bus.OutValid, bus.OutBit, bus.OutLast, bus.CodeLen);
        end
`ifdef COEFF_TOKEN_CHECK_EN
        vectors++;
        if (bus.Error !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_error: got %b want 0", bus.Error);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_codes();
        vec_t v[8];
        logic [15:0] bits;
        int n, lat, last_at, clen;
        bit held, rdy_lo;
        logic rdy_after;
        v[0] = '{5'd0,  5'd0,  2'd0, 1,  16'b1,                "nc0_tc0"};
        v[1] = '{5'd1,  5'd3,  2'd3, 5,  16'b00011,            "nc1_tc3_t3"};
        v[2] = '{5'd0,  5'd1,  2'd0, 6,  16'b000101,           "nc0_tc1_t0"};
        v[3] = '{5'd9,  5'd5,  2'd2, 6,  16'b010010,           "flc_tc5_t2"};
        v[4] = '{5'd16, 5'd0,  2'd0, 6,  16'b000011,           "flc_tc0"};
        v[5] = '{5'd16, 5'd16, 2'd3, 6,  16'b111111,           "flc_tc16_t3"};
        v[6] = '{5'd0,  5'd16, 2'd0, 16, 16'b0000000000000100, "nc0_tc16_max"};
        v[7] = '{5'd8,  5'd1,  2'd1, 6,  16'b000001,           "flc_thresh"};
        for (int i = 0; i < 8; i++) begin
            send(v[i].nc, v[i].tc, v[i].t1);
            collect(1'b0, bits, n, lat, last_at, clen, held, rdy_lo, rdy_after);
            vectors++;
            if (n != v[i].len || bits !== v[i].bits) begin
                miscompares++;
                $display("FAIL %s bits: got %0d'b%b want %0d'b%b", v[i].nm, n, bits, v[i].len, v[i].bits);
            end
            vectors++;
            if (clen != v[i].len || last_at != v[i].len) begin
                miscompares++;
                $display("FAIL %s len: got CodeLen=%0d last_at=%0d want %0d", v[i].nm, clen, last_at, v[i].len);
            end
            vectors++;
            if (lat != 1 || !rdy_lo || rdy_after !== 1'b1) begin
                miscompares++;
                $display("FAIL %s timing: got lat=%0d rdy_lo=%0d rdy_after=%b want 1 1 1",
                         v[i].nm, lat, rdy_lo, rdy_after);
            end
        end
    endtask

    task automatic test_stall();
        logic [15:0] bits;
        int n, lat, last_at, clen;
        bit held, rdy_lo;
        logic rdy_after;
        send(5'd0, 5'd2, 2'd0);
        collect(1'b1, bits, n, lat, last_at, clen, held, rdy_lo, rdy_after);
        vectors++;
        if (n != 8 || bits !== 16'b00000111) begin
            miscompares++;
            $display("FAIL stall_bits: got %0d'b%b want 8'b00000111", n, bits);
        end
        vectors++;
        if (!held || clen != 8 || last_at != 8) begin
            miscompares++;
            $display("FAIL stall_hold: got held=%0d len=%0d last_at=%0d want 1 8 8", held, clen, last_at);
        end
        vectors++;
        if (!rdy_lo || rdy_after !== 1'b1) begin
            miscompares++;
            $display("FAIL stall_inready: got rdy_lo=%0d rdy_after=%b want 1 1", rdy_lo, rdy_after);
        end
    endtask

    task automatic test_reset_mid_token();
        logic [15:0] bits;
        int n, lat, last_at, clen;
        bit held, rdy_lo;
        logic rdy_after;
        int vcnt;
        bus.OutReady = 1'b1;
        send(5'd0, 5'd2, 2'd0);
        @(posedge clk); #1;
        vectors++;
        if (bus.OutValid !== 1'b1 || bus.CodeLen !== 5'd8) begin
            miscompares++;
            $display("FAIL midrst_start: got vld=%b len=%0d want 1 8", bus.OutValid, bus.CodeLen);
        end
        repeat (3) begin @(posedge clk); #1; end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (bus.OutValid !== 1'b0 || bus.InReady !== 1'b1 || bus.OutLast !== 1'b0 || bus.CodeLen !== '0) begin
            miscompares++;
            $display("FAIL midrst_async: got vld=%b rdy=%b last=%b len=%0d want 0 1 0 0",
                     bus.OutValid, bus.InReady, bus.OutLast, bus.CodeLen);
        end
        #3;
        rst_n = 1'b1;
        vcnt = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (bus.OutValid === 1'b1) vcnt++;
        end
        vectors++;
        if (vcnt != 0) begin
            miscompares++;
            $display("FAIL midrst_noresume: got %0d valid cycles want 0", vcnt);
        end
        send(5'd0, 5'd1, 2'd1);
        collect(1'b0, bits, n, lat, last_at, clen, held, rdy_lo, rdy_after);
        vectors++;
        if (n != 2 || bits !== 16'b01 || last_at != 2 || clen != 2) begin
            miscompares++;
            $display("FAIL midrst_next: got %0d'b%b last_at=%0d len=%0d want 2'b01 2 2", n, bits, last_at, clen);
        end
    endtask

`ifdef COEFF_TOKEN_CHECK_EN
    task automatic test_illegal();
        logic [4:0] ncs[2];
        logic [4:0] tcs[2];
        logic [1:0] t1s[2];
        int errs, vals;
        ncs[0] = 5'd0; tcs[0] = 5'd1; t1s[0] = 2'd2;
        ncs[1] = 5'd4; tcs[1] = 5'd3; t1s[1] = 2'd1;
        for (int i = 0; i < 2; i++) begin
            send(ncs[i], tcs[i], t1s[i]);
            errs = 0; vals = 0;
            repeat (6) begin
                if (bus.Error === 1'b1) errs++;
                if (bus.OutValid === 1'b1) vals++;
                @(posedge clk); #1;
            end
            vectors++;
            if (errs != 1 || vals != 0 || bus.InReady !== 1'b1) begin
                miscompares++;
                $display("FAIL illegal_%0d: got err_cycles=%0d valid_cycles=%0d rdy=%b want 1 0 1",
                         i, errs, vals, bus.InReady);
            end
        end
    endtask
`else
    task automatic test_illegal();
        logic [4:0] ncs[2];
        logic [4:0] tcs[2];
        logic [1:0] t1s[2];
        logic [15:0] bits;
        int n, lat, last_at, clen;
        bit held, rdy_lo;
        logic rdy_after;
        ncs[0] = 5'd0; tcs[0] = 5'd1; t1s[0] = 2'd2;
        ncs[1] = 5'd4; tcs[1] = 5'd3; t1s[1] = 2'd1;
        for (int i = 0; i < 2; i++) begin
            send(ncs[i], tcs[i], t1s[i]);
            collect(1'b0, bits, n, lat, last_at, clen, held, rdy_lo, rdy_after);
            vectors++;
            if (n != 1 || last_at != 1 || clen != 1 || rdy_after !== 1'b1) begin
                miscompares++;
                $display("FAIL illegal_%0d: got n=%0d last_at=%0d len=%0d rdy=%b want 1 1 1 1",
                         i, n, last_at, clen, rdy_after);
            end
        end
    endtask
`endif

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_codes();
        test_stall();
        test_reset_mid_token();
        test_illegal();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
